// File: rtl/prod_ctrl_pkg.sv
// Shared definitions for the producer/buffer sequencing controller:
// one-hot state encoding (matches the LED bits), display-mode codes, word width.
package prod_ctrl_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [5:0] S_IDLE      = 6'b000001;
    localparam logic [5:0] S_COMM_F    = 6'b000010;
    localparam logic [5:0] S_WAIT_F    = 6'b000100;
    localparam logic [5:0] S_COMM_T    = 6'b001000;
    localparam logic [5:0] S_WAIT_T    = 6'b010000;
    localparam logic [5:0] S_BUF_EMPTY = 6'b100000;

    localparam logic [1:0] MOD_NONE  = 2'd0;
    localparam logic [1:0] MOD_FIB   = 2'd1;
    localparam logic [1:0] MOD_TIMER = 2'd2;

endpackage

// File: rtl/prod_ctrl_if.sv
// Bundle of button pulses, buffer flags, producer words and controller outputs.
// slave is the controller side, master is the surrounding datapath.
interface prod_ctrl_if;
    import prod_ctrl_pkg::*;

    logic       start_f;
    logic       start_t;
    logic       stop_f_t;
    logic       buffer_full;
    logic       buffer_empty;
    logic       data_2_valid;
    logic       f_valid;
    word_t      f_out;
    logic       t_valid;
    word_t      t_out;
    logic       f_en;
    logic       t_en;
    logic       data_1_en;
    word_t      data_1;
    logic [5:0] led;
    logic [1:0] modulo;
    word_t      wr_count;

    modport master (
        output start_f, start_t, stop_f_t, buffer_full, buffer_empty, data_2_valid,
               f_valid, f_out, t_valid, t_out,
        input  f_en, t_en, data_1_en, data_1, led, modulo, wr_count
    );

    modport slave (
        input  start_f, start_t, stop_f_t, buffer_full, buffer_empty, data_2_valid,
               f_valid, f_out, t_valid, t_out,
        output f_en, t_en, data_1_en, data_1, led, modulo, wr_count
    );

endinterface

// File: rtl/prod_ctrl_sat_counter16.sv
// 16-bit up counter with synchronous clear and enable; sticks at all-ones.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 16'h0000;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/prod_ctrl.sv
// Arbitrates the buffer write port between the Fibonacci and Timer producers,
// gates producer enables on occupancy, drains on stop, and reports status.
module prod_ctrl
    import prod_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    prod_ctrl_if.slave  bus
);

    logic [5:0] state;
    logic [5:0] next_state;
    logic [1:0] modulo_next;
    logic       cnt_clr;
    word_t      cnt_val;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.start_f)      next_state = S_COMM_F;
                else if (bus.start_t) next_state = S_COMM_T;
            end
            S_COMM_F: begin
                if (bus.stop_f_t)         next_state = S_BUF_EMPTY;
                else if (bus.buffer_full) next_state = S_WAIT_F;
            end
            S_WAIT_F: begin
                if (bus.stop_f_t)          next_state = S_BUF_EMPTY;
                else if (!bus.buffer_full) next_state = S_COMM_F;
            end
            S_COMM_T: begin
                if (bus.stop_f_t)         next_state = S_BUF_EMPTY;
                else if (bus.buffer_full) next_state = S_WAIT_T;
            end
            S_WAIT_T: begin
                if (bus.stop_f_t)          next_state = S_BUF_EMPTY;
                else if (!bus.buffer_full) next_state = S_COMM_T;
            end
            S_BUF_EMPTY: begin
                if (bus.buffer_empty && !bus.data_2_valid) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Display mode follows the state being entered, but keeps its format while draining.
    always_comb begin
        case (next_state)
            S_COMM_F, S_WAIT_F: modulo_next = MOD_FIB;
            S_COMM_T, S_WAIT_T: modulo_next = MOD_TIMER;
            S_BUF_EMPTY:        modulo_next = bus.modulo;
            default:            modulo_next = MOD_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bus.modulo <= MOD_NONE;
        end else begin
            state      <= next_state;
            bus.modulo <= modulo_next;
        end
    end

    assign bus.led       = state;
    assign bus.f_en      = (state == S_COMM_F) && !bus.buffer_full;
    assign bus.t_en      = (state == S_COMM_T) && !bus.buffer_full;
    assign bus.data_1_en = (bus.f_en && bus.f_valid) || (bus.t_en && bus.t_valid);

    always_comb begin
        case (state)
            S_COMM_F, S_WAIT_F: bus.data_1 = bus.f_out;
            S_COMM_T, S_WAIT_T: bus.data_1 = bus.t_out;
            default:            bus.data_1 = '0;
        endcase
    end

    // The count restarts only when production begins from idle, not on resume from WAIT.
    assign cnt_clr = (state == S_IDLE) && (bus.start_f || bus.start_t);

    sat_counter16 u_wr_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (bus.data_1_en),
        .count (cnt_val)
    );

    assign bus.wr_count = cnt_val;

endmodule
